// File: rtl/scu_pkg.sv
// scu_pkg: shared widths and operand/address types for the SCU pipeline registers
package scu_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 6;
  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/rf_read_port.sv
// rf_read_port: one registered read port with scoreboard lookup.
// Macro RF_WR_BYPASS_EN forwards a same-cycle write straight to the operand register.
module rf_read_port #(
  parameter int DATA_W = scu_pkg::DATA_W,
  parameter int ADDR_W = scu_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] mem_i [2**ADDR_W],
  input  logic [2**ADDR_W-1:0] busy_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  input  logic              accept_i,
  output logic              effbusy_o,
  output logic [DATA_W-1:0] rdata_o
);
`ifdef RF_WR_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  logic              hit;
  logic [DATA_W-1:0] rdata_d, rdata_q;
  assign hit       = BYPASS && we_i && (waddr_i == raddr_i);
  assign effbusy_o = busy_i[raddr_i] & ~hit;
  assign rdata_d   = accept_i ? (hit ? wdata_i : mem_i[raddr_i]) : rdata_q;
  assign rdata_o   = rdata_q;
  always_ff @(posedge clk)
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: 2-read/1-write register file with busy scoreboard and registered reads.
// Macro RF_WR_BYPASS_EN enables write-through forwarding on both read ports.
module reg_file_sb #(
  parameter int DATA_W  = scu_pkg::DATA_W,
  parameter int ADDR_W  = scu_pkg::ADDR_W,
  parameter bit ZERO_R0 = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic              hazard,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);
  localparam int NREG = 2**ADDR_W;
  logic [DATA_W-1:0] mem_q [NREG];
  logic [NREG-1:0]   busy_q, busy_d;
  logic              rvalid_q, wr_ok, iss_ok, accept, eb_a, eb_b;
  // r0 stays zero and never busy when hard-wired, so reads of it need no special case
  assign wr_ok  = we & ~(ZERO_R0 && waddr == '0);
  assign iss_ok = issue_en & ~(ZERO_R0 && issue_addr == '0);
  assign hazard = rst_n & rd_en & (eb_a | eb_b);
  assign accept = rd_en & ~hazard;
  assign rvalid = rvalid_q;
  always_comb begin
    busy_d = busy_q;
    if (wr_ok)  busy_d[waddr] = 1'b0;
    if (iss_ok) busy_d[issue_addr] = 1'b1;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
      busy_q   <= '0;
      rvalid_q <= 1'b0;
    end else begin
      if (wr_ok) mem_q[waddr] <= wdata;
      busy_q   <= busy_d;
      rvalid_q <= accept;
    end
  rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_a (
    .clk(clk), .rst_n(rst_n), .mem_i(mem_q), .busy_i(busy_q),
    .we_i(wr_ok), .waddr_i(waddr), .wdata_i(wdata),
    .raddr_i(raddr_a), .accept_i(accept), .effbusy_o(eb_a), .rdata_o(rdata_a)
  );
  rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_b (
    .clk(clk), .rst_n(rst_n), .mem_i(mem_q), .busy_i(busy_q),
    .we_i(wr_ok), .waddr_i(waddr), .wdata_i(wdata),
    .raddr_i(raddr_b), .accept_i(accept), .effbusy_o(eb_b), .rdata_o(rdata_b)
  );
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed and random checks of reg_file_sb (default and r0-hardwired instances).
module tb_reg_file_sb;
  logic        clk = 1'b0;
  logic        rst_n, we, issue_en, rd_en;
  logic [5:0]  waddr, issue_addr, raddr_a, raddr_b;
  logic [31:0] wdata;
  logic        hazard, rvalid, z_hazard, z_rvalid;
  logic [31:0] rdata_a, rdata_b, z_rdata_a, z_rdata_b;
  int          total = 0, bad = 0;
`ifdef RF_WR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic [31:0] m_mem [64];
  bit          m_busy [64];
  logic [31:0] m_ra, m_rb;
  logic        m_rv, hit_a, hit_b, m_hz;
  always #5 clk = ~clk;
  reg_file_sb dut (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .issue_en(issue_en), .issue_addr(issue_addr), .rd_en(rd_en),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .hazard(hazard), .rvalid(rvalid),
    .rdata_a(rdata_a), .rdata_b(rdata_b)
  );
  reg_file_sb #(.ZERO_R0(1'b1)) dz (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .issue_en(issue_en), .issue_addr(issue_addr), .rd_en(rd_en),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .hazard(z_hazard), .rvalid(z_rvalid),
    .rdata_a(z_rdata_a), .rdata_b(z_rdata_b)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    #2_000_000;
    $error("FAIL timeout: test did not finish");
    $finish;
  end
  initial begin
    rst_n = 1'b0; we = 1'b0; issue_en = 1'b0; rd_en = 1'b0;
    waddr = '0; issue_addr = '0; raddr_a = '0; raddr_b = '0; wdata = '0;
    repeat (2) tick();
    rst_n = 1'b1; we = 1'b1; waddr = 6'd5; wdata = 32'hDEADBEEF;
    tick();
    we = 1'b0; issue_en = 1'b1; issue_addr = 6'd5;
    tick();
    issue_en = 1'b0; rst_n = 1'b0; rd_en = 1'b1; raddr_a = 6'd5; raddr_b = 6'd5;
    #1;
    chk("rst_hazard", hazard, 1'b0);
    tick();
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_rdata_a", rdata_a, 32'h0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_hazard", hazard, 1'b0);
    tick();
    chk("post_rst_rvalid", rvalid, 1'b1);
    chk("post_rst_rdata_a", rdata_a, 32'h0);
    rd_en = 1'b0; we = 1'b1; waddr = 6'd3; wdata = 32'h12345678;
    tick();
    chk("idle_rvalid", rvalid, 1'b0);
    we = 1'b0; rd_en = 1'b1; raddr_a = 6'd3; raddr_b = 6'd3;
    #1;
    chk("basic_hazard", hazard, 1'b0);
    tick();
    chk("basic_rvalid", rvalid, 1'b1);
    chk("basic_rdata_a", rdata_a, 32'h12345678);
    chk("basic_rdata_b", rdata_b, 32'h12345678);
    rd_en = 1'b0;
    tick();
    chk("hold_rvalid", rvalid, 1'b0);
    chk("hold_rdata_a", rdata_a, 32'h12345678);
    issue_en = 1'b1; issue_addr = 6'd7;
    tick();
    issue_en = 1'b0; rd_en = 1'b1; raddr_a = 6'd3; raddr_b = 6'd7;
    #1;
    chk("sb_hazard1", hazard, 1'b1);
    tick();
    chk("sb_rvalid1", rvalid, 1'b0);
    chk("sb_rdata_b_hold", rdata_b, 32'h12345678);
    chk("sb_hazard2", hazard, 1'b1);
    we = 1'b1; waddr = 6'd7; wdata = 32'h55;
    #1;
`ifdef RF_WR_BYPASS_EN
    chk("sb_wr_hazard", hazard, 1'b0);
    tick();
    chk("sb_wr_rvalid", rvalid, 1'b1);
    chk("sb_wr_rdata_b", rdata_b, 32'h55);
    we = 1'b0;
`else
    chk("sb_wr_hazard", hazard, 1'b1);
    tick();
    chk("sb_wr_rvalid", rvalid, 1'b0);
    we = 1'b0;
    #1;
    chk("sb_after_hazard", hazard, 1'b0);
    tick();
    chk("sb_after_rvalid", rvalid, 1'b1);
    chk("sb_after_rdata_b", rdata_b, 32'h55);
`endif
    issue_en = 1'b1; issue_addr = 6'd3; raddr_a = 6'd3; raddr_b = 6'd3;
    #1;
    chk("iss_rd_hazard", hazard, 1'b0);
    tick();
    issue_en = 1'b0;
    chk("iss_rd_rvalid", rvalid, 1'b1);
    chk("iss_rd_rdata_a", rdata_a, 32'h12345678);
    #1;
    chk("iss_rd_next_hazard", hazard, 1'b1);
    rd_en = 1'b0; we = 1'b1; waddr = 6'd9; wdata = 32'hA; issue_en = 1'b1; issue_addr = 6'd9;
    tick();
    we = 1'b0; issue_en = 1'b0; rd_en = 1'b1; raddr_a = 6'd9; raddr_b = 6'd9;
    #1;
    chk("setwin_hazard", hazard, 1'b1);
    rd_en = 1'b0; we = 1'b1; waddr = 6'd0; wdata = 32'hFFFF; issue_en = 1'b1; issue_addr = 6'd0;
    tick();
    we = 1'b0; issue_en = 1'b0; rd_en = 1'b1; raddr_a = 6'd0; raddr_b = 6'd0;
    #1;
    chk("r0_z_hazard", z_hazard, 1'b0);
    chk("r0_dut_hazard", hazard, 1'b1);
    tick();
    chk("r0_z_rvalid", z_rvalid, 1'b1);
    chk("r0_z_rdata_a", z_rdata_a, 32'h0);
    chk("r0_z_rdata_b", z_rdata_b, 32'h0);
    rst_n = 1'b0; rd_en = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) begin m_mem[i] = '0; m_busy[i] = 1'b0; end
    m_ra = '0; m_rb = '0; m_rv = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      we = ($urandom_range(0, 2) == 0); waddr = 6'($urandom_range(0, 7)); wdata = $urandom;
      issue_en = ($urandom_range(0, 3) == 0); issue_addr = 6'($urandom_range(0, 7));
      rd_en = ($urandom_range(0, 3) != 0);
      raddr_a = 6'($urandom_range(0, 7)); raddr_b = 6'($urandom_range(0, 7));
      hit_a = BYP && we && (waddr == raddr_a);
      hit_b = BYP && we && (waddr == raddr_b);
      m_hz = rd_en && ((m_busy[raddr_a] && !hit_a) || (m_busy[raddr_b] && !hit_b));
      #1;
      chk("rnd_hazard", hazard, m_hz);
      m_rv = rd_en && !m_hz;
      if (m_rv) begin
        m_ra = hit_a ? wdata : m_mem[raddr_a];
        m_rb = hit_b ? wdata : m_mem[raddr_b];
      end
      if (we) begin m_mem[waddr] = wdata; m_busy[waddr] = 1'b0; end
      if (issue_en) m_busy[issue_addr] = 1'b1;
      tick();
      chk("rnd_rvalid", rvalid, m_rv);
      chk("rnd_rdata_a", rdata_a, m_ra);
      chk("rnd_rdata_b", rdata_b, m_rb);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
